// File: rtl/io_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_regbank_pkg
// Description : Shared constants, helpers and types for the multi-channel
//               IO register bank (io_regbank_arb, rr_arbiter).
//               Optional feature macro: IO_REGBANK_ERR_EN (see io_regbank_arb).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package io_regbank_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_NUM_CH = 2;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Response bundle at the default geometry; the top declares the
    // parametrised equivalent for its actual NUM_CH / DATA_W.
    typedef struct packed {
        logic [DEF_NUM_CH-1:0] valid;
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_def_t;

endpackage
`default_nettype wire

// File: rtl/io_regbank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Grants the first requester at or after
//               the pointer; the pointer moves past the winner on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import io_regbank_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    localparam int CH_W  = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    logic            found;

    // Scan channels starting at ptr with wrap-around; first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, ptr} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            idx = sum[CH_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Pointer moves to winner+1 (wrapping) on a transfer, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_regbank_arb.sv
`default_nettype none
// ============================================================================
// Module      : io_regbank_arb
// Description : NUM_CH requesters share one DEPTH x DATA_W register array via
//               a round-robin arbiter. One access per clock, one-cycle
//               registered read latency, single-cycle response pulses.
//               Optional macro IO_REGBANK_ERR_EN adds the rsp_err port and
//               error responses for out-of-range accesses.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module io_regbank_arb
    import io_regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata
`ifdef IO_REGBANK_ERR_EN
    ,
    output logic                     rsp_err
`endif
);

    localparam int CH_W = ch_width(NUM_CH);

    typedef struct packed {
        logic [NUM_CH-1:0] valid;
        logic [DATA_W-1:0] rdata;
`ifdef IO_REGBANK_ERR_EN
        logic              err;
`endif
    } rsp_q_t;

    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              xfer;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [DATA_W-1:0] mem [DEPTH];
    rsp_q_t            rsp_q;

    // Nothing is granted while in reset or while access is disabled.
    assign arb_req = req_valid & {NUM_CH{enable & ~rst}};

    rr_arbiter #(
        .NUM_CH    (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    // Route the winning channel's payload onto the shared access path.
    always_comb begin
        sel_write = req_write[grant_idx];
        sel_addr  = req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[int'(grant_idx) * DATA_W +: DATA_W];
        in_range  = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));
    end

    // Register array write port; out-of-range writes are dropped. No reset.
    always_ff @(posedge clk) begin
        if (xfer && sel_write && in_range) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // Response register: one-cycle pulse for reads (and error writes).
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q.valid <= '0;
            rsp_q.rdata <= '0;
`ifdef IO_REGBANK_ERR_EN
            rsp_q.err   <= 1'b0;
`endif
        end else begin
            rsp_q.valid <= '0;
            if (xfer && !sel_write) begin
                rsp_q.valid <= grant;
                rsp_q.rdata <= in_range ? mem[sel_addr] : '0;
`ifdef IO_REGBANK_ERR_EN
                rsp_q.err   <= ~in_range;
            end else if (xfer && !in_range) begin
                rsp_q.valid <= grant;
                rsp_q.rdata <= '0;
                rsp_q.err   <= 1'b1;
`endif
            end
        end
    end

    // A response that lands while reset is asserted is dropped.
    assign rsp_valid = rsp_q.valid & {NUM_CH{~rst}};
    assign rsp_rdata = rsp_q.rdata;
`ifdef IO_REGBANK_ERR_EN
    assign rsp_err   = rsp_q.err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_regbank_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_regbank_arb
// Description : Directed self-checking bench for io_regbank_arb
//               (NUM_CH=4, DEPTH=200). Honours IO_REGBANK_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_regbank_arb;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
    localparam int NUM_CH = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_write;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
`ifdef IO_REGBANK_ERR_EN
    logic                     rsp_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_cnt [NUM_CH];

    io_regbank_arb #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .NUM_CH    (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
`ifdef IO_REGBANK_ERR_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [7:0] addr, input logic [7:0] data);
        req_valid[ch]                   = 1'b1;
        req_write[ch]                   = wr;
        req_addr[ch*ADDR_W +: ADDR_W]   = addr;
        req_wdata[ch*DATA_W +: DATA_W]  = data;
    endtask

    task automatic clr_req(input int ch);
        req_valid[ch] = 1'b0;
    endtask

    // Single-channel access: checks the grant, runs one edge, drops the request.
    task automatic access(input int ch, input logic wr, input logic [7:0] addr, input logic [7:0] data);
        set_req(ch, wr, addr, data);
        #2;
        chk("grant", 32'(req_ready), 32'(1 << ch));
        step();
        clr_req(ch);
        #2;
    endtask

    task automatic read_chk(input string tag, input int ch, input logic [7:0] addr,
                            input logic [7:0] exp, input logic exp_err);
        access(ch, 1'b0, addr, 8'h00);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(1 << ch));
        chk({tag, "_data"}, 32'(rsp_rdata), 32'(exp));
`ifdef IO_REGBANK_ERR_EN
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
`else
        if (exp_err) chk({tag, "_err_unused"}, 32'(rsp_valid), 32'(1 << ch));
`endif
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        req_valid = '1;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int c = 0; c < NUM_CH; c++) rsp_cnt[c] = 0;

        // Reset state
        step();
        step();
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h0);
`ifdef IO_REGBANK_ERR_EN
        chk("rst_err", 32'(rsp_err), 32'h0);
`endif
        rst       = 1'b0;
        req_valid = '0;

        // Basic access: write 0x10=0xA5, read it back the next cycle
        set_req(0, 1'b1, 8'h10, 8'hA5);
        #2;
        chk("basic_wr_grant", 32'(req_ready), 32'h1);
        step();
        set_req(0, 1'b0, 8'h10, 8'h00);
        #2;
        chk("basic_rd_grant", 32'(req_ready), 32'h1);
        chk("basic_wr_norsp", 32'(rsp_valid), 32'h0);
        step();
        clr_req(0);
        #2;
        chk("basic_rd_valid", 32'(rsp_valid), 32'h1);
        chk("basic_rd_data", 32'(rsp_rdata), 32'hA5);

        // Preload 0x20..0x23 = 0xD0..0xD3, then reset so ptr = 0 (array keeps data)
        for (int i = 0; i < 4; i++) access(0, 1'b1, 8'(8'h20 + i), 8'(8'hD0 + i));
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Fairness: all four channels read continuously for 8 grants
        for (int c = 0; c < NUM_CH; c++) set_req(c, 1'b0, 8'(8'h20 + c), 8'h00);
        for (int k = 0; k < 8; k++) begin
            #2;
            chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("fair_rsp", 32'(rsp_valid), 32'(1 << ((k - 1) % 4)));
                chk("fair_data", 32'(rsp_rdata), 32'(8'hD0 + ((k - 1) % 4)));
            end
            for (int c = 0; c < NUM_CH; c++) if (rsp_valid[c]) rsp_cnt[c]++;
            step();
        end

        // Enable gating: last fairness response completes while enable is low
        req_valid = '0;
        enable    = 1'b0;
        set_req(1, 1'b0, 8'h21, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("en_ready", 32'(req_ready), 32'h0);
            if (k == 0) begin
                chk("en_inflight", 32'(rsp_valid), 32'h8);
                chk("en_inflight_data", 32'(rsp_rdata), 32'hD3);
            end else begin
                chk("en_norsp", 32'(rsp_valid), 32'h0);
            end
            for (int c = 0; c < NUM_CH; c++) if (rsp_valid[c]) rsp_cnt[c]++;
            step();
        end
        for (int c = 0; c < NUM_CH; c++) chk("fair_count", 32'(rsp_cnt[c]), 32'd2);

        enable = 1'b1;
        set_req(3, 1'b0, 8'h23, 8'h00);
        #2;
        chk("en_ch1_first", 32'(req_ready), 32'h2);
        step();
        clr_req(1);
        #2;
        chk("en_ch1_rsp", 32'(rsp_valid), 32'h2);
        chk("en_ch1_data", 32'(rsp_rdata), 32'hD1);
        chk("en_ch3_grant", 32'(req_ready), 32'h8);
        step();
        clr_req(3);
        #2;
        chk("en_ch3_rsp", 32'(rsp_valid), 32'h8);
        chk("en_ch3_data", 32'(rsp_rdata), 32'hD3);

        // Out-of-range accesses (DEPTH = 200)
        access(2, 1'b1, 8'hF0, 8'h77);
`ifdef IO_REGBANK_ERR_EN
        chk("oor_wr_valid", 32'(rsp_valid), 32'h4);
        chk("oor_wr_err", 32'(rsp_err), 32'h1);
        chk("oor_wr_data", 32'(rsp_rdata), 32'h0);
`else
        chk("oor_wr_norsp", 32'(rsp_valid), 32'h0);
        chk("oor_wr_hold", 32'(rsp_rdata), 32'hD3);
`endif
        read_chk("oor_rd_f0", 2, 8'hF0, 8'h00, 1'b1);
        access(2, 1'b1, 8'hC7, 8'h5A);
        read_chk("rd_c7", 2, 8'hC7, 8'h5A, 1'b0);
        access(2, 1'b1, 8'hC8, 8'h66);
        read_chk("oor_rd_c8", 2, 8'hC8, 8'h00, 1'b1);
        access(2, 1'b1, 8'h00, 8'h11);
        read_chk("rd_00", 2, 8'h00, 8'h11, 1'b0);

        // Interleave, ch1 read ahead of ch0 write: prior value returned
        rst = 1'b1;
        step();
        rst = 1'b0;
        access(0, 1'b1, 8'h05, 8'h99);
        set_req(0, 1'b1, 8'h05, 8'h3C);
        set_req(1, 1'b0, 8'h05, 8'h00);
        #2;
        chk("ilv_b_grant", 32'(req_ready), 32'h2);
        step();
        clr_req(1);
        #2;
        chk("ilv_b_rsp", 32'(rsp_valid), 32'h2);
        chk("ilv_b_data", 32'(rsp_rdata), 32'h99);
        chk("ilv_b_wr_grant", 32'(req_ready), 32'h1);
        step();
        clr_req(0);

        // Interleave after reset: ch0 wins first, ch1 then sees the new data
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 8'h05, 8'h4D);
        set_req(1, 1'b0, 8'h05, 8'h00);
        #2;
        chk("ilv_a_ch0_first", 32'(req_ready), 32'h1);
        step();
        clr_req(0);
        #2;
        chk("ilv_a_rd_grant", 32'(req_ready), 32'h2);
        step();
        clr_req(1);
        #2;
        chk("ilv_a_rsp", 32'(rsp_valid), 32'h2);
        chk("ilv_a_data", 32'(rsp_rdata), 32'h4D);

        // Reset mid-operation: read granted, reset in the response cycle
        set_req(1, 1'b0, 8'h10, 8'h00);
        #2;
        chk("midrst_grant", 32'(req_ready), 32'h2);
        step();
        clr_req(1);
        rst = 1'b1;
        #2;
        chk("midrst_drop", 32'(rsp_valid), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        #2;
        chk("midrst_after", 32'(rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
